// File: rtl/spi_slave_pkg.sv
// Shared types and edge-selection helper for the SPI word slave.
package spi_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic sample_rise;
        logic shift_rise;
    } edge_sel_t;

    // Lead edge is the rise when SCLK idles low; CPHA moves sampling to the trail edge.
    function automatic edge_sel_t sel_edges(input logic cpol, input logic cpha);
        edge_sel_t sel;
        logic      lead_rise;
        lead_rise       = ~cpol;
        sel.sample_rise = cpha ? ~lead_rise : lead_rise;
        sel.shift_rise  = ~sel.sample_rise;
        return sel;
    endfunction

endpackage

// File: rtl/spi_slave_word_sync.sv
// One-bit multi-stage synchroniser with rise/fall strobes on the synchronised level.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out,
    output logic rise_out,
    output logic fall_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_out    = sync_q[STAGES-1];
    assign rise_out = sync_q[STAGES-1] & ~prev_q;
    assign fall_out = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_word.sv
// Full-duplex SPI slave: deserialises MOSI into words and serialises tx words onto MISO.
module spi_slave_word
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  spi_sclk_in,
    input  logic                  spi_mosi_in,
    input  logic                  spi_cs_n_in,
    output logic                  spi_miso_out,
    output logic                  spi_miso_oe_out,
    output logic                  rx_rdy_out,
    output logic                  rx_first_out,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  tx_load_out,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic                  frame_end_out
);

    localparam int        CW   = $clog2(DATA_WIDTH);
    localparam edge_sel_t ESEL = sel_edges(CPOL != 0, CPHA != 0);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic cs_lvl_unused, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sync_sclk (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(spi_sclk_in),
        .q_out(sclk_lvl_unused), .rise_out(sclk_rise), .fall_out(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(spi_mosi_in),
        .q_out(mosi_s), .rise_out(mosi_rise_unused), .fall_out(mosi_fall_unused)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(spi_cs_n_in),
        .q_out(cs_lvl_unused), .rise_out(cs_rise), .fall_out(cs_fall)
    );

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_rdy_q, rx_rdy_d;
    logic                  rx_first_q, rx_first_d;
    logic                  oe_q, oe_d;
    logic                  frame_end_q, frame_end_d;
    logic                  reload_q, reload_d;
    logic                  skip_q, skip_d;
    logic                  tx_load;
    logic                  sample_edge, shift_edge;
    logic [DATA_WIDTH-1:0] rx_shift, tx_shift;

    assign sample_edge = ESEL.sample_rise ? sclk_rise : sclk_fall;
    assign shift_edge  = ESEL.shift_rise  ? sclk_rise : sclk_fall;

    always_comb begin
        rx_shift = (MSB_FIRST != 0) ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s}
                                    : {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
        tx_shift = (MSB_FIRST != 0) ? {tx_sr_q[DATA_WIDTH-2:0], 1'b0}
                                    : {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        first_d     = first_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        rx_rdy_d    = 1'b0;
        rx_first_d  = 1'b0;
        oe_d        = oe_q;
        frame_end_d = 1'b0;
        reload_d    = reload_q;
        skip_d      = skip_q;
        tx_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    tx_load   = 1'b1;
                    tx_sr_d   = tx_data_in;
                    bit_cnt_d = '0;
                    first_d   = 1'b1;
                    oe_d      = 1'b1;
                    reload_d  = 1'b0;
                    skip_d    = (CPHA != 0);
                end
            end
            ACTIVE: begin
                // CS release takes priority over any edge seen in the same cycle.
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                    oe_d        = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_sr_d = rx_shift;
                        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                            bit_cnt_d  = '0;
                            rx_rdy_d   = 1'b1;
                            rx_data_d  = rx_shift;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            reload_d   = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else if (reload_q) begin
                            tx_load  = 1'b1;
                            tx_sr_d  = tx_data_in;
                            reload_d = 1'b0;
                        end else begin
                            tx_sr_d = tx_shift;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_rdy_q    <= 1'b0;
            rx_first_q  <= 1'b0;
            oe_q        <= 1'b0;
            frame_end_q <= 1'b0;
            reload_q    <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_rdy_q    <= rx_rdy_d;
            rx_first_q  <= rx_first_d;
            oe_q        <= oe_d;
            frame_end_q <= frame_end_d;
            reload_q    <= reload_d;
            skip_q      <= skip_d;
        end
    end

    assign spi_miso_out    = oe_q & ((MSB_FIRST != 0) ? tx_sr_q[DATA_WIDTH-1] : tx_sr_q[0]);
    assign spi_miso_oe_out = oe_q;
    assign rx_rdy_out      = rx_rdy_q;
    assign rx_first_out    = rx_first_q;
    assign rx_data_out     = rx_data_q;
    assign tx_load_out     = tx_load;
    assign frame_end_out   = frame_end_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench: five slaves (modes 0-3 at 8 bits MSB-first, mode 0 at 16 bits LSB-first) driven by a behavioural SPI master.
module tb_spi_slave_word;

    typedef struct {
        int          inst;
        logic        first;
        logic [15:0] data;
    } rx_ev_t;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [4:0] sclk;
    logic [4:0] cs_n;
    logic       mosi;
    wire  [4:0] miso, oe, rdy, first, load, fend;
    wire  [7:0] rx8 [4];
    wire  [7:0] tx8 [4];
    wire [15:0] rx16, tx16;

    logic [15:0] tx_mem [5][80];
    logic [15:0] mosi_words [80];
    int          tx_ptr [5]       = '{default: 0};
    int          tx_ptr_shown [5] = '{default: 0};
    int          load_cnt [5]     = '{default: 0};
    int          fend_cnt [5]     = '{default: 0};
    rx_ev_t      rx_q [$];
    bit          miso_bits [$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_word #(.DATA_WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut (
            .clk_in(clk_in), .rst_n_in(rst_n_in), .spi_sclk_in(sclk[g]), .spi_mosi_in(mosi),
            .spi_cs_n_in(cs_n[g]), .spi_miso_out(miso[g]), .spi_miso_oe_out(oe[g]),
            .rx_rdy_out(rdy[g]), .rx_first_out(first[g]), .rx_data_out(rx8[g]),
            .tx_load_out(load[g]), .tx_data_in(tx8[g]), .frame_end_out(fend[g])
        );
        assign tx8[g] = tx_mem[g][tx_ptr_shown[g] % 80][7:0];
    end

    spi_slave_word #(.DATA_WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut16 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .spi_sclk_in(sclk[4]), .spi_mosi_in(mosi),
        .spi_cs_n_in(cs_n[4]), .spi_miso_out(miso[4]), .spi_miso_oe_out(oe[4]),
        .rx_rdy_out(rdy[4]), .rx_first_out(first[4]), .rx_data_out(rx16),
        .tx_load_out(load[4]), .tx_data_in(tx16), .frame_end_out(fend[4])
    );
    assign tx16 = tx_mem[4][tx_ptr_shown[4] % 80];

    // Strobes are sampled mid-cycle; the tx word pointer advances only after the next active edge.
    always @(negedge clk_in) begin
        for (int i = 0; i < 5; i++) begin
            if (rdy[i]) rx_q.push_back('{inst: i, first: first[i], data: (i == 4) ? rx16 : {8'h00, rx8[i]}});
            if (load[i]) tx_ptr[i]++;
            if (fend[i]) fend_cnt[i]++;
            if (load[i]) load_cnt[i]++;
        end
    end

    always @(posedge clk_in) begin
        #1;
        for (int i = 0; i < 5; i++) tx_ptr_shown[i] = tx_ptr[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dw_of(input int inst);
        return (inst == 4) ? 16 : 8;
    endfunction

    task automatic frame(input int inst, input int nbits, input int half, input bit end_cs);
        int dw;
        bit msb, cpol, cpha;
        dw   = dw_of(inst);
        msb  = (inst != 4);
        cpol = (inst < 4) ? inst[1] : 1'b0;
        cpha = (inst < 4) ? inst[0] : 1'b0;
        cs_n[inst] = 1'b0;
        repeat (10) @(negedge clk_in);
        for (int b = 0; b < nbits; b++) begin
            logic [15:0] word;
            int          pos;
            word = mosi_words[b / dw];
            pos  = msb ? (dw - 1 - (b % dw)) : (b % dw);
            if (!cpha) begin
                mosi = word[pos];
                repeat (half) @(negedge clk_in);
                miso_bits.push_back(miso[inst]);
                sclk[inst] = ~cpol;
                repeat (half) @(negedge clk_in);
                sclk[inst] = cpol;
            end else begin
                sclk[inst] = ~cpol;
                mosi = word[pos];
                repeat (half) @(negedge clk_in);
                miso_bits.push_back(miso[inst]);
                sclk[inst] = cpol;
                repeat (half) @(negedge clk_in);
            end
        end
        repeat (half) @(negedge clk_in);
        if (end_cs) begin
            cs_n[inst] = 1'b1;
            repeat (10) @(negedge clk_in);
        end
    endtask

    // Runs one complete frame of nw words and checks it against the spec-level expectations.
    task automatic xfer_check(input string tag, input int inst, input int nw, input int half, input bit chk_miso);
        int          dw, p0, l0, f0, exp_loads;
        bit          msb;
        logic [15:0] mask, wv, exp_tx;
        dw   = dw_of(inst);
        msb  = (inst != 4);
        mask = (dw == 8) ? 16'h00FF : 16'hFFFF;
        p0   = tx_ptr[inst];
        l0   = load_cnt[inst];
        f0   = fend_cnt[inst];
        rx_q.delete();
        miso_bits.delete();
        frame(inst, nw * dw, half, 1'b1);
        chk($sformatf("%s_nrdy", tag), rx_q.size(), nw);
        for (int k = 0; k < nw && k < rx_q.size(); k++) begin
            chk($sformatf("%s_data%0d", tag, k), rx_q[k].data, mosi_words[k] & mask);
            chk($sformatf("%s_first%0d", tag, k), rx_q[k].first, (k == 0));
            chk($sformatf("%s_inst%0d", tag, k), rx_q[k].inst, inst);
        end
        chk($sformatf("%s_rxhold", tag), (inst == 4) ? rx16 : {8'h00, rx8[inst]}, mosi_words[nw - 1] & mask);
        if (chk_miso) begin
            for (int k = 0; k < nw; k++) begin
                wv = '0;
                for (int j = 0; j < dw; j++) wv[msb ? (dw - 1 - j) : j] = miso_bits[k * dw + j];
                exp_tx = tx_mem[inst][(p0 + k) % 80] & mask;
                chk($sformatf("%s_miso%0d", tag, k), wv, exp_tx);
            end
        end
        // One load at CS fall, plus one on each shift edge that follows a completed word.
        exp_loads = ((inst < 4) && inst[0]) ? nw : nw + 1;
        chk($sformatf("%s_loads", tag), load_cnt[inst] - l0, exp_loads);
        chk($sformatf("%s_fend", tag), fend_cnt[inst] - f0, 1);
        chk($sformatf("%s_oe_idle", tag), oe[inst], 1'b0);
    endtask

    task automatic set_tx(input int inst, input int k, input logic [15:0] v);
        tx_mem[inst][(tx_ptr[inst] + k) % 80] = v;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) for (int k = 0; k < 80; k++) tx_mem[i][k] = 16'($urandom);
        rst_n_in = 1'b0;
        sclk     = 5'b01100;
        cs_n     = 5'b11111;
        mosi     = 1'b0;
        repeat (3) @(negedge clk_in);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rst_out%0d", i), {miso[i], oe[i], rdy[i], first[i], load[i], fend[i], rx8[i]}, 32'h0);
        chk("rst_out4", {miso[4], oe[4], rdy[4], first[4], load[4], fend[4], rx16}, 32'h0);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);

        // Mode 0 two-word frame
        mosi_words[0] = 16'h00A5; mosi_words[1] = 16'h003C;
        set_tx(0, 0, 16'h0096); set_tx(0, 1, 16'h000F);
        xfer_check("m0", 0, 2, 6, 1'b1);

        // Modes 1..3, one word each
        for (int m = 1; m < 4; m++) begin
            mosi_words[0] = 16'h00C3;
            set_tx(m, 0, 16'h005A);
            xfer_check($sformatf("mode%0d", m), m, 1, 6, 1'b1);
        end

        // 16-bit LSB-first
        mosi_words[0] = 16'h1234;
        set_tx(4, 0, 16'hBEEF);
        xfer_check("w16", 4, 1, 6, 1'b1);

        // Randomised frames on every instance
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                int nw;
                nw = $urandom_range(1, 3);
                for (int k = 0; k < nw; k++) begin
                    mosi_words[k] = (i == 4) ? 16'($urandom) : {8'h00, 8'($urandom)};
                    set_tx(i, k, 16'($urandom));
                end
                xfer_check($sformatf("rnd%0d_%0d", r, i), i, nw, 6, 1'b1);
            end
        end

        // Truncated frame: 5 bits of 0xFF then CS release
        begin
            int          f0;
            logic [7:0]  held;
            held = rx8[0];
            f0   = fend_cnt[0];
            rx_q.delete();
            mosi_words[0] = 16'h00FF;
            frame(0, 5, 6, 1'b1);
            chk("trunc_nrdy", rx_q.size(), 0);
            chk("trunc_fend", fend_cnt[0] - f0, 1);
            chk("trunc_hold", rx8[0], held);
        end
        mosi_words[0] = 16'h0081;
        xfer_check("after_trunc", 0, 1, 6, 1'b1);

        // Asynchronous reset in the middle of a word
        mosi_words[0] = 16'h00FF;
        frame(0, 3, 6, 1'b0);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_out", {miso[0], oe[0], rdy[0], first[0], load[0], fend[0], rx8[0]}, 32'h0);
        @(negedge clk_in);
        cs_n[0] = 1'b1;
        sclk[0] = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("midrst_hold", {oe[0], rdy[0], fend[0], rx8[0]}, 32'h0);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        mosi_words[0] = 16'h0042;
        xfer_check("after_rst", 0, 1, 6, 1'b1);

        // 64 back-to-back bytes at SCLK = clk_in/4
        for (int k = 0; k < 64; k++) begin
            mosi_words[k] = 16'(k);
            set_tx(0, k, 16'($urandom));
        end
        xfer_check("b2b", 0, 64, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
